// File: rtl/mc_ctrl_fsm.sv
// Multicycle main-control FSM: decodes opcode/funct, sequences the datapath through
// fetch/decode/execute/memory/writeback, and aborts stalled memory waits with a watchdog.
module mc_ctrl_fsm #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_ctrl,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MADDR  = 4'd3;
  localparam logic [3:0] S_MRD    = 4'd4;
  localparam logic [3:0] S_MWB    = 4'd5;
  localparam logic [3:0] S_MWR    = 4'd6;
  localparam logic [3:0] S_REXE   = 4'd7;
  localparam logic [3:0] S_RWB    = 4'd8;
  localparam logic [3:0] S_BR     = 4'd9;
  localparam logic [3:0] S_JMP    = 4'd10;
  localparam logic [3:0] S_JAL    = 4'd11;
  localparam logic [3:0] S_JR     = 4'd12;
  localparam logic [3:0] S_IEXE   = 4'd13;
  localparam logic [3:0] S_IWB    = 4'd14;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

  logic [3:0] state_q, state_d;
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       is_sw_q, is_sw_d;
  logic       is_bne_q, is_bne_d;
  logic       wait_st, wd_expire, funct_ok;

  always_comb begin
    wait_st   = (state_q == S_FETCH) || (state_q == S_MRD) || (state_q == S_MWR);
    // A completing access wins over an expiring watchdog in the same cycle.
    wd_expire = wait_st && (TIMEOUT_C != 8'd0) && (wd_cnt_q == TIMEOUT_C) && !mem_ready;
    funct_ok  = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  end

  // NOTE: every signal written in this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    is_sw_d    = is_sw_q;
    is_bne_d   = is_bne_q;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    pc_source  = 2'd0;
    alu_ctrl   = ALU_AND;
    illegal_op = 1'b0;
    bus_err    = wd_expire;

    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'd1;
        alu_ctrl  = ALU_ADD;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        if (mem_ready)      state_d = S_DECODE;
        else if (wd_expire) state_d = S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_ctrl  = ALU_ADD;
        is_sw_d   = (opcode == 6'h2B);
        is_bne_d  = (opcode == 6'h05);
        case (opcode)
          6'h00: begin
            if (funct == 6'h08) state_d = S_JR;
            else if (funct_ok)  state_d = S_REXE;
            else begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          end
          6'h23, 6'h2B: state_d = S_MADDR;
          6'h04, 6'h05: state_d = S_BR;
          6'h02:        state_d = S_JMP;
          6'h03:        state_d = S_JAL;
          6'h08:        state_d = S_IEXE;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_ctrl  = ALU_ADD;
        state_d   = is_sw_q ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (mem_ready)      state_d = S_MWB;
        else if (wd_expire) state_d = S_FETCH;
      end
      S_MWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 2'd1;
        state_d    = S_FETCH;
      end
      S_MWR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        if (mem_ready || wd_expire) state_d = S_FETCH;
      end
      S_REXE: begin
        alu_src_a = 1'b1;
        case (funct)
          6'h22:   alu_ctrl = ALU_SUB;
          6'h24:   alu_ctrl = ALU_AND;
          6'h25:   alu_ctrl = ALU_OR;
          6'h2A:   alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
        state_d = S_RWB;
      end
      S_RWB: begin
        reg_we  = 1'b1;
        reg_dst = 2'd1;
        state_d = S_FETCH;
      end
      S_BR: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_source = 2'd1;
        pc_we     = zero ^ is_bne_q;
        state_d   = S_FETCH;
      end
      S_JMP: begin
        pc_we     = 1'b1;
        pc_source = 2'd2;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        pc_we      = 1'b1;
        pc_source  = 2'd2;
        reg_we     = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        state_d    = S_FETCH;
      end
      S_JR: begin
        pc_we     = 1'b1;
        pc_source = 2'd3;
        state_d   = S_FETCH;
      end
      S_IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_ctrl  = ALU_ADD;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Counter restarts whenever a wait state is (re)entered, including after a timeout.
    wd_cnt_d = (wait_st && (state_d == state_q) && !wd_expire) ? wd_cnt_q + 8'd1 : 8'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RST;
      wd_cnt_q <= 8'd0;
      is_sw_q  <= 1'b0;
      is_bne_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wd_cnt_q <= wd_cnt_d;
      is_sw_q  <= is_sw_d;
      is_bne_q <= is_bne_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: inputs change on the falling edge, outputs are
// checked 1 time unit later against hand-computed values.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_rd, mem_wr, iord, ir_we, pc_we, reg_we;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic       alu_src_a, illegal_op, bus_err;
  logic [2:0] alu_ctrl;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  mc_ctrl_fsm #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord),
    .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_ctrl(alu_ctrl), .illegal_op(illegal_op),
    .bus_err(bus_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  logic [19:0] all_outs;
  assign all_outs = {mem_rd, mem_wr, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg,
                     alu_src_a, alu_src_b, pc_source, alu_ctrl, illegal_op, bus_err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, apply mem_ready, let outputs settle.
  task automatic cyc(input logic rdy);
    @(negedge clk);
    mem_ready = rdy;
    #1;
  endtask

  task automatic do_fetch(input logic [5:0] op, input logic [5:0] fn, input string tag);
    opcode = op;
    funct  = fn;
    cyc(1'b1);
    check({tag, " fetch state"}, state_o, 1);
    check({tag, " fetch ir_we"}, ir_we, 1);
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

    // 1. reset
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0);
      check("rst state", state_o, 0);
      check("rst outs", all_outs, 0);
    end
    rst_n = 1'b1;
    #1 check("rst release state", state_o, 0);
    cyc(1'b0);
    check("first fetch state", state_o, 1);
    check("first fetch mem_rd", mem_rd, 1);
    check("first fetch ir_we idle", ir_we, 0);

    // 2. add
    do_fetch(6'h00, 6'h20, "add");
    check("add fetch pc_we", pc_we, 1);
    check("add fetch src_b", alu_src_b, 1);
    cyc(1'b1);
    check("add decode state", state_o, 2);
    check("add decode src_b", alu_src_b, 3);
    check("add decode illegal", illegal_op, 0);
    cyc(1'b1);
    check("add rexe state", state_o, 7);
    check("add rexe alu", alu_ctrl, 3'b010);
    check("add rexe src_b", alu_src_b, 0);
    check("add rexe src_a", alu_src_a, 1);
    cyc(1'b1);
    check("add rwb state", state_o, 8);
    check("add rwb reg_we", reg_we, 1);
    check("add rwb reg_dst", reg_dst, 1);

    // slt through REXE
    do_fetch(6'h00, 6'h2A, "slt");
    cyc(1'b1);
    cyc(1'b1);
    check("slt rexe alu", alu_ctrl, 3'b111);
    cyc(1'b1);

    // 3. lw with mem_ready delayed 3 cycles
    do_fetch(6'h23, 6'h00, "lw");
    cyc(1'b1);
    check("lw decode state", state_o, 2);
    cyc(1'b0);
    check("lw maddr state", state_o, 3);
    check("lw maddr src_b", alu_src_b, 2);
    for (int i = 0; i < 4; i++) begin
      cyc(i == 3);
      check("lw mrd state", state_o, 4);
      check("lw mrd rd/iord", {mem_rd, iord}, 2'b11);
      check("lw mrd bus_err", bus_err, 0);
    end
    cyc(1'b0);
    check("lw mwb state", state_o, 5);
    check("lw mwb reg_we", reg_we, 1);
    check("lw mwb mem_to_reg", mem_to_reg, 1);
    check("lw mwb reg_dst", reg_dst, 0);

    // 4. beq / bne: both zero values checked within the one BR cycle
    do_fetch(6'h04, 6'h00, "beq");
    cyc(1'b1);
    cyc(1'b1);
    zero = 1'b1; #1;
    check("beq state", state_o, 9);
    check("beq z=1 pc_we", pc_we, 1);
    check("beq pc_source", pc_source, 1);
    check("beq alu", alu_ctrl, 3'b110);
    zero = 1'b0; #1;
    check("beq z=0 pc_we", pc_we, 0);
    do_fetch(6'h05, 6'h00, "bne");
    check("bne timing", state_o, 1);
    cyc(1'b1);
    cyc(1'b1);
    zero = 1'b1; #1;
    check("bne z=1 pc_we", pc_we, 0);
    zero = 1'b0; #1;
    check("bne z=0 pc_we", pc_we, 1);

    // 5. jal, jr, addi, illegal opcode and funct
    do_fetch(6'h03, 6'h00, "jal");
    cyc(1'b1);
    cyc(1'b1);
    check("jal state", state_o, 11);
    check("jal we", {pc_we, reg_we}, 2'b11);
    check("jal reg_dst", reg_dst, 2);
    check("jal mem_to_reg", mem_to_reg, 2);
    check("jal pc_source", pc_source, 2);
    do_fetch(6'h00, 6'h08, "jr");
    cyc(1'b1);
    cyc(1'b1);
    check("jr state", state_o, 12);
    check("jr pc_source", pc_source, 3);
    do_fetch(6'h08, 6'h00, "addi");
    cyc(1'b1);
    cyc(1'b1);
    check("addi iexe state", state_o, 13);
    cyc(1'b1);
    check("addi iwb state", state_o, 14);
    check("addi iwb reg_dst", reg_dst, 0);
    do_fetch(6'h3F, 6'h00, "illop");
    cyc(1'b1);
    check("illop decode state", state_o, 2);
    check("illop pulse", illegal_op, 1);
    cyc(1'b0);
    check("illop back to fetch", state_o, 1);
    check("illop pulse ends", illegal_op, 0);
    opcode = 6'h00; funct = 6'h21;
    cyc(1'b1);
    cyc(1'b1);
    check("illfn pulse", illegal_op, 1);

    // 6. watchdog in FETCH: bus_err on the 5th stalled cycle
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0);
      check("wd fetch state", state_o, 1);
      check("wd fetch ir_we", ir_we, 0);
      check("wd fetch bus_err", bus_err, (i == 4));
    end
    // mem_ready arriving on the timeout cycle wins
    opcode = 6'h2B;
    for (int i = 0; i < 5; i++) begin
      cyc(i == 4);
      check("wd race bus_err", bus_err, 0);
    end
    check("wd race ir_we", ir_we, 1);
    cyc(1'b1);
    check("sw decode state", state_o, 2);
    cyc(1'b0);
    check("sw maddr state", state_o, 3);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0);
      check("sw mwr state", state_o, 6);
      check("sw mwr bus_err", bus_err, (i == 4));
    end
    cyc(1'b0);
    check("mwr timeout -> fetch", state_o, 1);

    // async reset in the middle of MWR
    do_fetch(6'h2B, 6'h00, "sw2");
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    check("sw2 mwr mem_wr", mem_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst mem_wr", mem_wr, 0);
    check("async rst state", state_o, 0);
    cyc(1'b0);
    rst_n = 1'b1;
    cyc(1'b0);
    check("post rst fetch", state_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
